stream_fifo: RTL and testbench

- Synchronous valid/ready FIFO placed directly upstream of the testcase consumer module.
- Decouples a bursty producer from a consumer that stalls intermittently.
- Provides first-word-fall-through output, an occupancy count and full/empty/almost-full flags.
- Single clock domain; no clock crossing.

---
 rtl/stream_fifo_pkg.sv | 23 ++
 rtl/stream_fifo_if.sv | 32 +++
 rtl/stream_fifo_mem.sv | 27 ++
 rtl/stream_fifo.sv | 82 ++++++++
 tb/tb_stream_fifo.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared types, defaults and parameter-legality helpers for the stream FIFO.
package stream_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 8;
    localparam int unsigned DEFAULT_DEPTH       = 4;
    localparam int unsigned DEFAULT_AFULL_LEVEL = 3;

    // Pointer width: one extra MSB over the address so full and empty differ.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    // Depth must be a power of two and at least 2.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Almost-full threshold must lie in 1..depth.
    function automatic bit afull_ok(input int unsigned level, input int unsigned depth);
        return (level >= 1) && (level <= depth);
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Producer/consumer handshake bundle around the FIFO.
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;

    // FIFO side.
    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, count, empty, full, almost_full
    );

    // Producer/consumer side.
    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, count, empty, full, almost_full
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port, combinational from storage.
    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count and flags.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned AFULL_LEVEL = DEFAULT_AFULL_LEVEL
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Elaboration-time parameter legality.
    if (WIDTH < 1) begin : g_bad_width
        $error("stream_fifo: WIDTH must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two >= 2");
    end
    if (!afull_ok(AFULL_LEVEL, DEPTH)) begin : g_bad_afull
        $error("stream_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rdata;

    // Occupancy and flags decoded purely from registered pointers.
    assign count = CW'(wptr - rptr);
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Handshakes; ready/valid never depend on the opposite-side inputs.
    assign push = bus.i_valid & ~full;
    assign pop  = bus.o_ready & ~empty;

    // Pointer update; reset discards contents and ignores same-cycle handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & rst_n),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.i_data),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

    // Bus outputs.
    assign bus.i_ready     = ~full;
    assign bus.o_valid     = ~empty;
    assign bus.o_data      = rdata;
    assign bus.count       = count;
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count >= CW'(AFULL_LEVEL));

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo with a queue-based reference model.
module tb_stream_fifo;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned AF = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [W-1:0] model [$];

    stream_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and update the reference model from the rules.
    task automatic tick();
        bit p;
        bit q;
        p = rst_n && bus.i_valid && (model.size() < D);
        q = rst_n && bus.o_ready && (model.size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            model.delete();
        end else begin
            if (q) void'(model.pop_front());
            if (p) model.push_back(bus.i_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.i_valid = 1'b0; bus.o_ready = 1'b0; bus.i_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready: got %b want 1", bus.i_ready); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", bus.almost_full); end
    endtask

    task automatic test_fill();
        bus.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = 1'b1; bus.i_data = W'(8'h11 * (i + 1));
            tick();
            n_cmp++; if (bus.almost_full !== (i >= 2)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.almost_full, (i >= 2)); end
            n_cmp++; if (bus.count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
        end
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", bus.full); end
        n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL fill_i_ready: got %b want 0", bus.i_ready); end
        bus.i_data = 8'h55;
        tick();
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL fill_5th_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.o_data !== 8'h11) begin n_err++; $display("FAIL fill_head: got %h want 11", bus.o_data); end
    endtask

    task automatic test_drain();
        logic [W-1:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.o_valid); end
            n_cmp++; if (bus.o_data !== exp[i]) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.o_data, exp[i]); end
            tick();
        end
        bus.o_ready = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_simul_wrap();
        logic [W-1:0] prior [2];
        logic [W-1:0] exp;
        bus.o_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prior[i] = W'($urandom);
            bus.i_valid = 1'b1; bus.i_data = prior[i];
            tick();
        end
        bus.o_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.i_data = W'(8'hA0 + k);
            exp = (k < 2) ? prior[k] : W'(8'hA0 + k - 2);
            n_cmp++; if (bus.o_data !== exp) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", k, bus.o_data, exp); end
            tick();
            n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 2", k, bus.count); end
        end
        bus.i_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp = W'(8'hA8 + k);
            n_cmp++; if (bus.o_data !== exp) begin n_err++; $display("FAIL wrap_tail[%0d]: got %h want %h", k, bus.o_data, exp); end
            tick();
        end
        bus.o_ready = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_pop();
        logic [W-1:0] w [4];
        logic [W-1:0] tail [3];
        bus.o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = W'($urandom);
            bus.i_valid = 1'b1; bus.i_data = w[i];
            tick();
        end
        bus.i_data = 8'h99; bus.o_ready = 1'b1;
        n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL fp_c1_ready: got %b want 0", bus.i_ready); end
        n_cmp++; if (bus.o_data !== w[0]) begin n_err++; $display("FAIL fp_c1_data: got %h want %h", bus.o_data, w[0]); end
        tick();
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL fp_c1_count: got %0d want 3", bus.count); end
        n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL fp_c2_ready: got %b want 1", bus.i_ready); end
        n_cmp++; if (bus.o_data !== w[1]) begin n_err++; $display("FAIL fp_c2_data: got %h want %h", bus.o_data, w[1]); end
        tick();
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL fp_c2_count: got %0d want 3", bus.count); end
        tail = '{w[2], w[3], 8'h99};
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.o_data !== tail[i]) begin n_err++; $display("FAIL fp_tail[%0d]: got %h want %h", i, bus.o_data, tail[i]); end
            tick();
        end
        bus.o_ready = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fp_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        bus.o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; bus.i_data = W'($urandom);
            tick();
        end
        rst_n = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'h77; bus.o_ready = 1'b1;
        tick();
        rst_n = 1'b1; bus.i_valid = 1'b0; bus.o_ready = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.o_valid); end
        bus.i_valid = 1'b1; bus.i_data = 8'h5A;
        tick();
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL rstmid_count1: got %0d want 1", bus.count); end
        n_cmp++; if (bus.o_data !== 8'h5A) begin n_err++; $display("FAIL rstmid_first: got %h want 5a", bus.o_data); end
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        bus.i_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                bus.i_valid = ($urandom_range(0, 3) != 0);
                bus.i_data  = W'($urandom);
            end
            bus.o_ready = ($urandom_range(0, 2) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            n_cmp++; if (bus.count !== 3'(model.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.count, model.size()); end
            n_cmp++; if (bus.i_ready !== (model.size() < D)) begin n_err++; $display("FAIL rnd_i_ready[%0d]: got %b want %b", c, bus.i_ready, (model.size() < D)); end
            n_cmp++; if (bus.o_valid !== (model.size() > 0)) begin n_err++; $display("FAIL rnd_o_valid[%0d]: got %b want %b", c, bus.o_valid, (model.size() > 0)); end
            n_cmp++; if (bus.almost_full !== (model.size() >= AF)) begin n_err++; $display("FAIL rnd_afull[%0d]: got %b want %b", c, bus.almost_full, (model.size() >= AF)); end
            if (model.size() > 0) begin
                n_cmp++; if (bus.o_data !== model[0]) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, bus.o_data, model[0]); end
            end
            hold = bus.i_valid && (model.size() >= D);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        for (int c = 0; c < D + 1; c++) tick();
        bus.o_ready = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rnd_final_empty: got %b want 1", bus.empty); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_simul_wrap();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
